pipe_mem_access_ctrl: RTL

PIPE_MEM_ACCESS_CTRL -- requirements
Module: pipe_mem_access_ctrl

---
 rtl/pipe_mem_access_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipe_mem_access_ctrl.sv
// pipe_mem_access_ctrl: MEM-stage data bus controller that stalls the pipeline,
// checks alignment, steers byte lanes and aborts accesses on bus timeout.
module pipe_mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_dmem_ena,
    input  logic        mem_dmem_wena,
    input  logic [1:0]  mem_dmem_w_cs,
    input  logic [1:0]  mem_dmem_r_cs,
    input  logic        mem_cutter_sign,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rt_data_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err
);
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_next;

    logic [1:0]    cs, size_q, lo_q;
    logic          sign_q, is_half, is_byte, legal, timeout;
    logic [CW-1:0] cnt;
    logic [3:0]    be;
    logic [31:0]   wdata, lane, ext;

    assign cs      = mem_dmem_wena ? mem_dmem_w_cs : mem_dmem_r_cs;
    assign is_half = cs == 2'b01;
    assign is_byte = cs == 2'b10;
    assign legal   = mem_dmem_ena && (is_byte || (is_half ? !mem_alu_out[0] : mem_alu_out[1:0] == 2'b00));
    assign be      = is_byte ? 4'b0001 << mem_alu_out[1:0] :
                     is_half ? (mem_alu_out[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata   = is_byte ? {4{mem_rt_data_out[7:0]}} :
                     is_half ? {2{mem_rt_data_out[15:0]}} : mem_rt_data_out;
    // Bring the addressed lane down to bit 0, then extend by latched size
    assign lane    = bus_rdata >> {lo_q, 3'b000};
    assign ext     = size_q == 2'b10 ? {{24{sign_q & lane[7]}}, lane[7:0]} :
                     size_q == 2'b01 ? {{16{sign_q & lane[15]}}, lane[15:0]} : bus_rdata;
    assign timeout = cnt == CW'(TIMEOUT - 1);
    assign bus_req = state == ACCESS;

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        misalign_err = 1'b0;
        case (state)
            IDLE: begin
                stall        = legal;
                misalign_err = mem_dmem_ena && !legal;
                state_next   = legal ? ACCESS : IDLE;
            end
            ACCESS: begin
                stall      = 1'b1;
                state_next = (bus_ack || timeout) ? DONE : ACCESS;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= '0;
            bus_wdata <= '0;
            load_data <= '0;
            bus_err   <= 1'b0;
            cnt       <= '0;
            size_q    <= 2'b00;
            lo_q      <= 2'b00;
            sign_q    <= 1'b0;
        end else begin
            state   <= state_next;
            bus_err <= 1'b0;
            if (state == IDLE && legal) begin
                bus_addr  <= {mem_alu_out[31:2], 2'b00};
                bus_be    <= be;
                bus_we    <= mem_dmem_wena;
                bus_wdata <= wdata;
                size_q    <= cs;
                lo_q      <= mem_alu_out[1:0];
                sign_q    <= mem_cutter_sign;
                cnt       <= '0;
            end else if (state == IDLE && mem_dmem_ena) begin
                load_data <= '0;
            end else if (state == ACCESS && bus_ack) begin
                if (!bus_we) load_data <= ext;
            end else if (state == ACCESS && timeout) begin
                bus_err   <= 1'b1;
                load_data <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
